// File: rtl/rv32i_pkg.sv
// RV32I class codes, opcodes and per-format immediate packing shared by the
// instruction encoder and its FIFO front end.
package rv32i_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Each helper places only the immediate bits; all other fields are zero.
  function automatic logic [31:0] pack_i(input logic [11:0] imm);
    return {imm, 20'b0};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm);
    return {imm[11:5], 13'b0, imm[4:0], 7'b0};
  endfunction

  function automatic logic [31:0] pack_b(input logic [12:1] imm);
    return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:12] imm);
    return {imm, 12'b0};
  endfunction

  function automatic logic [31:0] pack_j(input logic [20:1] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x 32 synchronous FIFO with occupancy count; storage is not reset,
// the read port shows zero while empty.
module instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr, do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? 32'h0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a word FIFO with a byte-address counter.
// Define INSTR_ENC_CHECK_EN to drop illegal requests and flag them on err/err_cnt.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_fun3,
  input  logic        in_fun7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  logic [31:0] enc_word;
  logic        is_shift;
  logic        accept, wr_en, pop;
  logic        full, empty;

  assign is_shift = (in_fun3 == 3'b001) || (in_fun3 == 3'b101);

  always_comb begin
    enc_word = NOP_WORD;
    case (in_class)
      CLS_R:      enc_word = {1'b0, in_fun7, 5'b0, in_rs2, in_rs1, in_fun3, in_rd, OP_R};
      CLS_I:      enc_word = is_shift
                    ? {1'b0, in_fun7, 5'b0, in_imm[4:0], in_rs1, in_fun3, in_rd, OP_I}
                    : pack_i(in_imm[11:0]) | {12'b0, in_rs1, in_fun3, in_rd, OP_I};
      CLS_LOAD:   enc_word = pack_i(in_imm[11:0]) | {12'b0, in_rs1, in_fun3, in_rd, OP_LOAD};
      CLS_STORE:  enc_word = pack_s(in_imm[11:0]) | {7'b0, in_rs2, in_rs1, in_fun3, 5'b0, OP_STORE};
      CLS_BRANCH: enc_word = pack_b(in_imm[12:1]) | {7'b0, in_rs2, in_rs1, in_fun3, 5'b0, OP_BRANCH};
      CLS_JAL:    enc_word = pack_j(in_imm[20:1]) | {20'b0, in_rd, OP_JAL};
      CLS_JALR:   enc_word = pack_i(in_imm[11:0]) | {12'b0, in_rs1, in_fun3, in_rd, OP_JALR};
      CLS_LUI:    enc_word = pack_u(in_imm[31:12]) | {20'b0, in_rd, OP_LUI};
      CLS_AUIPC:  enc_word = pack_u(in_imm[31:12]) | {20'b0, in_rd, OP_AUIPC};
      default:    enc_word = NOP_WORD;
    endcase
  end

  assign accept = in_valid & in_ready;

`ifdef INSTR_ENC_CHECK_EN
  function automatic logic req_legal(input logic [3:0] cls, input logic [2:0] f3,
                                     input logic f7, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (cls)
      CLS_R:      if (f7 && !(f3 == 3'b000 || f3 == 3'b101)) ok = 1'b0;
      CLS_I: begin
        if (f7 && f3 != 3'b101) ok = 1'b0;
        if ((f3 == 3'b001 || f3 == 3'b101) && imm[11:5] != 7'b0) ok = 1'b0;
      end
      CLS_LOAD:   if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ok = 1'b0;
      CLS_STORE:  if (f3 > 3'b010) ok = 1'b0;
      CLS_BRANCH: if (f3 == 3'b010 || f3 == 3'b011 || imm[0]) ok = 1'b0;
      CLS_JAL:    if (imm[0]) ok = 1'b0;
      CLS_JALR:   if (f3 != 3'b000) ok = 1'b0;
      CLS_LUI, CLS_AUIPC: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic legal;
  assign legal = req_legal(in_class, in_fun3, in_fun7, in_imm);
  assign wr_en = accept & legal;

  // Illegal requests still handshake; they only bump the sticky flag and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else if (accept && !legal) begin
      err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign wr_en   = accept;
  assign err     = 1'b0;
  assign err_cnt = 8'd0;
`endif

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (enc_word),
    .rd_en   (pop),
    .rd_data (out_instr),
    .full    (full),
    .empty   (empty)
  );

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_addr <= BASE_ADDR;
    else if (pop) out_addr <= out_addr + 32'd4;
  end

endmodule
